// File: rtl/eff_sel_ctrl_pkg.sv
// Shared types and arithmetic for the click-free effect-selection controller.
// The gain multiply is done at a fixed wide width so one helper serves any sample/gain size.
package eff_sel_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    SETTLE   = 2'd2,
    FADE_IN  = 2'd3
  } ctrl_state_t;

  localparam int MUL_W = 64;

  // (sample * gain) >>> frac_bits, clamped to a signed out_bits range.
  function automatic logic signed [MUL_W-1:0] sat_mul(
    input logic signed [MUL_W-1:0] sample,
    input logic signed [MUL_W-1:0] gain,
    input int                      frac_bits,
    input int                      out_bits
  );
    logic signed [MUL_W-1:0] prod;
    logic signed [MUL_W-1:0] shifted;
    logic signed [MUL_W-1:0] one;
    logic signed [MUL_W-1:0] max_v;
    logic signed [MUL_W-1:0] min_v;
    one     = 1;
    prod    = sample * gain;
    shifted = prod >>> frac_bits;
    max_v   = (one <<< (out_bits - 1)) - one;
    min_v   = -max_v - one;
    if (shifted > max_v) begin
      sat_mul = max_v;
    end else if (shifted < min_v) begin
      sat_mul = min_v;
    end else begin
      sat_mul = shifted;
    end
  endfunction

endpackage

// File: rtl/eff_sel_ctrl_if.sv
// Sample stream between the effect pipeline output and the codec.
// Handshake: vld_i is a single-cycle strobe with no ready/backpressure; data_i is meaningful only
// while vld_i=1. vld_o/data_o follow exactly one clock later, and data_o holds between strobes.
interface eff_sel_ctrl_if #(
  parameter int DATA_WIDTH = 24
);
  logic signed [DATA_WIDTH-1:0] data_i;
  logic                         vld_i;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         vld_o;

  modport master (
    output data_i,
    output vld_i,
    input  data_o,
    input  vld_o
  );

  modport slave (
    input  data_i,
    input  vld_i,
    output data_o,
    output vld_o
  );
endinterface

// File: rtl/eff_debounce.sv
// Two-flop synchroniser followed by a stability counter; dout only follows din once the
// synchronised word has been unchanged for CYCLES clocks.
module eff_debounce #(
  parameter int WIDTH  = 17,
  parameter int CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int            CW      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/eff_sel_ctrl.sv
// Click-free effect selection: on a debounced switch change, fade the pipeline output to
// silence, apply the new en/sel, hold muted while the pipeline flushes, then fade back in.
module eff_sel_ctrl
  import eff_sel_ctrl_pkg::*;
#(
  parameter int SEL_WIDTH       = 16,
  parameter int DATA_WIDTH      = 24,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GAIN_BITS       = 6,
  parameter int SETTLE_SAMPLES  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_WIDTH-1:0] sw_i,
  input  logic                 en_i,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 en_o,
  output logic                 busy_o,
  output ctrl_state_t          dbg_state_o,
  output logic [GAIN_BITS:0]   dbg_gain_o,
  eff_sel_ctrl_if.slave        smp
);

  localparam int                 WORD_W    = SEL_WIDTH + 1;
  localparam int                 CNT_W     = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SETTLE_SAMPLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [GAIN_BITS:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};
  localparam logic [GAIN_BITS:0] GAIN_ONE  = (GAIN_BITS + 1)'(1);
  localparam logic [GAIN_BITS:0] GAIN_LAST = GAIN_FULL - GAIN_ONE;

  logic [WORD_W-1:0] stable_word;
  logic              pending;

  ctrl_state_t                  state_q, state_d;
  logic [GAIN_BITS:0]           gain_q, gain_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SEL_WIDTH-1:0]         sel_q, sel_d;
  logic                         en_q, en_d;
  logic                         busy_q, busy_d;
  logic signed [DATA_WIDTH-1:0] data_q, data_d;
  logic                         vld_q, vld_d;

  eff_debounce #(
    .WIDTH  (WORD_W),
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  ({en_i, sw_i}),
    .dout (stable_word)
  );

  assign pending = (stable_word != {en_q, sel_q});

  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    en_d    = en_q;
    vld_d   = smp.vld_i;
    data_d  = data_q;
    // The sample always sees the gain that was current before this cycle's update.
    if (smp.vld_i) begin
      data_d = DATA_WIDTH'(sat_mul(MUL_W'(smp.data_i), MUL_W'(gain_q), GAIN_BITS, DATA_WIDTH));
    end
    case (state_q)
      IDLE: begin
        if (pending) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        // A reversal from FADE_IN at gain 0 has nothing left to ramp down.
        if (gain_q == '0 || (smp.vld_i && gain_q == GAIN_ONE)) begin
          state_d         = SETTLE;
          gain_d          = '0;
          cnt_d           = '0;
          {en_d, sel_d}   = stable_word;
        end else if (smp.vld_i) begin
          gain_d = gain_q - GAIN_ONE;
        end
      end
      SETTLE: begin
        if (pending) begin
          {en_d, sel_d} = stable_word;
          cnt_d         = '0;
        end else if (smp.vld_i) begin
          if (cnt_q == CNT_LAST) state_d = FADE_IN;
          else                   cnt_d   = cnt_q + CNT_ONE;
        end
      end
      FADE_IN: begin
        if (pending) begin
          state_d = FADE_OUT;
        end else if (smp.vld_i) begin
          gain_d = gain_q + GAIN_ONE;
          if (gain_q == GAIN_LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gain_q  <= GAIN_FULL;
      cnt_q   <= '0;
      sel_q   <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      vld_q   <= vld_d;
    end
  end

  assign sel_o       = sel_q;
  assign en_o        = en_q;
  assign busy_o      = busy_q;
  assign dbg_state_o = state_q;
  assign dbg_gain_o  = gain_q;
  assign smp.data_o  = data_q;
  assign smp.vld_o   = vld_q;

endmodule

// File: tb/tb_eff_sel_ctrl.sv
// Directed bench for eff_sel_ctrl: short debounce, 4-bit gain, 4-sample settle, vld_i every 4 clk.
module tb_eff_sel_ctrl;
  import eff_sel_ctrl_pkg::*;

  localparam int SW = 16;
  localparam int DW = 24;
  localparam int GB = 4;

  logic          clk;
  logic          rst;
  logic [SW-1:0] sw;
  logic          en;
  logic [SW-1:0] sel_o;
  logic          en_o;
  logic          busy_o;
  ctrl_state_t   dbg_state;
  logic [GB:0]   dbg_gain;

  int errors = 0;
  int checks = 0;

  // Output level for data_i=1000 at gain 0..16: (1000*g)>>>4.
  logic signed [DW-1:0] lvl [0:16] = '{0, 62, 125, 187, 250, 312, 375, 437, 500,
                                       562, 625, 687, 750, 812, 875, 937, 1000};

  eff_sel_ctrl_if #(.DATA_WIDTH(DW)) smp ();

  eff_sel_ctrl #(
    .SEL_WIDTH       (SW),
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (8),
    .GAIN_BITS       (GB),
    .SETTLE_SAMPLES  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_i        (sw),
    .en_i        (en),
    .sel_o       (sel_o),
    .en_o        (en_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state),
    .dbg_gain_o  (dbg_gain),
    .smp         (smp)
  );

  // clock / reset / free-running sample strobe
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int ph;
    ph = 0;
    smp.vld_i = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      smp.vld_i = (ph == 0);
      ph = (ph == 3) ? 0 : ph + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver / wait tasks
  task automatic wait_out(output logic signed [DW-1:0] d, output bit ok);
    ok = 1'b0;
    d  = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (smp.vld_o) begin
        d  = smp.data_o;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input ctrl_state_t st, input int g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state == st && (g < 0 || int'(dbg_gain) == g)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic prev_vld;
    rst = 1'b1; sw = '0; en = 1'b0; smp.data_i = 24'sd1000;
    repeat (3) @(negedge clk);
    checks++; if (sel_o !== 16'h0) begin errors++; $display("FAIL reset_sel: got %h expected 0", sel_o); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL reset_en: got %b expected 0", en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    checks++; if (smp.vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", smp.vld_o); end
    checks++; if (smp.data_o !== 24'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", smp.data_o); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    checks++; if (dbg_gain !== 5'd16) begin errors++; $display("FAIL reset_gain: got %0d expected 16", dbg_gain); end
    rst = 1'b0;
    prev_vld = smp.vld_i;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (smp.vld_o !== prev_vld) begin
        errors++; $display("FAIL latency_vld: got %b expected %b", smp.vld_o, prev_vld);
      end
      if (smp.vld_o) begin
        checks++;
        if (smp.data_o !== 24'sd1000) begin
          errors++; $display("FAIL passthru_data: got %0d expected 1000", smp.data_o);
        end
      end
      prev_vld = smp.vld_i;
    end
  endtask

  task automatic test_fade_sequence();
    logic signed [DW-1:0] d;
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    bit ok, done, seen_zero, busy_seen;
    logic [SW-1:0] first_sel, sel_z;
    logic en_z;
    int n;
    done = 0; seen_zero = 0; busy_seen = 0; first_sel = 'x; sel_z = 'x; en_z = 1'bx;
    sw = 16'h0001; en = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      wait_out(d, ok);
      if (!ok) break;
      if (i == 0) first_sel = sel_o;
      if (busy_o) busy_seen = 1;
      if (d == 0 && !seen_zero) begin seen_zero = 1; sel_z = sel_o; en_z = en_o; end
      got_q.push_back(d);
      if (seen_zero && d == 24'sd1000 && !busy_o) done = 1;
    end
    checks++; if (!done) begin errors++; $display("FAIL fade_done: got 0 expected 1 (sequence incomplete)"); end
    checks++; if (!busy_seen) begin errors++; $display("FAIL fade_busy: got 0 expected 1"); end
    checks++; if (first_sel !== 16'h0000) begin errors++; $display("FAIL fade_old_sel: got %h expected 0000", first_sel); end
    checks++; if (sel_z !== 16'h0001) begin errors++; $display("FAIL fade_sel_at_zero: got %h expected 0001", sel_z); end
    checks++; if (en_z !== 1'b1) begin errors++; $display("FAIL fade_en_at_zero: got %b expected 1", en_z); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL fade_busy_end: got %b expected 0", busy_o); end
    while (got_q.size() > 0 && got_q[0] == 24'd1000) void'(got_q.pop_front());
    for (int g = 15; g >= 1; g--) exp_q.push_back(lvl[g]);
    repeat (5) exp_q.push_back('0);
    for (int g = 1; g <= 15; g++) exp_q.push_back(lvl[g]);
    exp_q.push_back(lvl[16]);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL fade_len: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin
        errors++; $display("FAIL fade_sample[%0d]: got %0d expected %0d", k, $signed(got_q[k]), $signed(exp_q[k]));
      end
    end
  endtask

  task automatic test_glitch_absorb();
    int busy_hits, rises;
    logic prev_busy;
    busy_hits = 0; rises = 0;
    for (int i = 0; i < 14; i++) begin
      sw = (i % 2 == 0) ? 16'h0000 : 16'h0001;
      repeat (3) begin
        @(negedge clk);
        if (busy_o) busy_hits++;
      end
    end
    checks++; if (busy_hits != 0) begin errors++; $display("FAIL glitch_busy: got %0d busy cycles expected 0", busy_hits); end
    sw = 16'h0002;
    prev_busy = busy_o;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy_o && !prev_busy) rises++;
      prev_busy = busy_o;
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL glitch_fades: got %0d expected 1", rises); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", busy_o); end
    checks++; if (sel_o !== 16'h0002) begin errors++; $display("FAIL glitch_sel: got %h expected 0002", sel_o); end
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL glitch_en: got %b expected 1", en_o); end
  endtask

  task automatic test_reverse_in_fade_in();
    logic signed [DW-1:0] d;
    bit ok, hit_zero;
    int idx, prev_idx, peak, bad, step_bad, full_hit, early_sel, n;
    logic [SW-1:0] sel_z;
    hit_zero = 0; bad = 0; step_bad = 0; full_hit = 0; early_sel = 0; peak = -1; prev_idx = -1; n = 0;
    sel_z = 'x;
    sw = 16'h0003;
    wait_state(FADE_IN, 10, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rev_reach_g10: got timeout expected FADE_IN gain 10"); end
    sw = 16'h0004;
    for (int i = 0; i < 60 && !hit_zero; i++) begin
      wait_out(d, ok);
      if (!ok) break;
      idx = -1;
      for (int k = 0; k <= 16; k++) if (d == lvl[k]) idx = k;
      if (idx < 0) bad++;
      if (n > 0 && ((idx > prev_idx) ? idx - prev_idx : prev_idx - idx) > 1) step_bad++;
      if (idx == 16) full_hit++;
      if (idx > peak) peak = idx;
      if (idx >= 2 && sel_o !== 16'h0003) early_sel++;
      if (d == 0) begin hit_zero = 1; sel_z = sel_o; end
      prev_idx = idx;
      n++;
    end
    checks++; if (!hit_zero) begin errors++; $display("FAIL rev_zero: got 0 expected 1 (never muted)"); end
    checks++; if (bad != 0) begin errors++; $display("FAIL rev_level: got %0d off-table samples expected 0", bad); end
    checks++; if (step_bad != 0) begin errors++; $display("FAIL rev_step: got %0d gain jumps expected 0", step_bad); end
    checks++; if (full_hit != 0) begin errors++; $display("FAIL rev_full: got %0d full-gain samples expected 0", full_hit); end
    checks++; if (peak < 10) begin errors++; $display("FAIL rev_peak: got %0d expected >=10", peak); end
    checks++; if (early_sel != 0) begin errors++; $display("FAIL rev_early_sel: got %0d samples with new sel expected 0", early_sel); end
    checks++; if (sel_z !== 16'h0004) begin errors++; $display("FAIL rev_sel_at_zero: got %h expected 0004", sel_z); end
    wait_state(IDLE, -1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rev_idle: got timeout expected IDLE"); end
    checks++; if (sel_o !== 16'h0004) begin errors++; $display("FAIL rev_final_sel: got %h expected 0004", sel_o); end
  endtask

  task automatic test_saturation();
    logic signed [DW-1:0] d;
    bit ok;
    @(negedge clk);
    smp.data_i = 24'sh800000;
    wait_out(d, ok);
    checks++; if (!ok || d !== 24'sh800000) begin errors++; $display("FAIL sat_full: got %0d expected -8388608", d); end
    sw = 16'h0005;
    wait_state(FADE_OUT, 8, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_reach_g8: got timeout expected FADE_OUT gain 8"); end
    wait_out(d, ok);
    checks++; if (!ok || d !== 24'shC00000) begin errors++; $display("FAIL sat_half: got %0d expected -4194304", d); end
    wait_state(IDLE, -1, 400, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_idle: got timeout expected IDLE"); end
    smp.data_i = 24'sd1000;
  endtask

  task automatic test_reset_in_settle();
    logic signed [DW-1:0] d;
    bit ok;
    sw = 16'h0006;
    wait_state(SETTLE, -1, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_reach_settle: got timeout expected SETTLE"); end
    rst = 1'b1; sw = '0; en = 1'b0;
    @(negedge clk);
    checks++; if (sel_o !== 16'h0) begin errors++; $display("FAIL rst_sel: got %h expected 0", sel_o); end
    checks++; if (en_o !== 1'b0) begin errors++; $display("FAIL rst_en: got %b expected 0", en_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy_o); end
    checks++; if (dbg_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
    checks++; if (dbg_gain !== 5'd16) begin errors++; $display("FAIL rst_gain: got %0d expected 16", dbg_gain); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_out(d, ok);
    checks++; if (!ok || d !== 24'sd1000) begin errors++; $display("FAIL rst_resume: got %0d expected 1000", d); end
    wait_out(d, ok);
    checks++; if (!ok || d !== 24'sd1000) begin errors++; $display("FAIL rst_resume2: got %0d expected 1000", d); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b expected 0", busy_o); end
  endtask

  // sequence and final report
  initial begin
    rst = 1'b1; sw = '0; en = 1'b0; smp.data_i = 24'sd1000;
    test_reset();
    test_fade_sequence();
    test_glitch_absorb();
    test_reverse_in_fade_in();
    test_saturation();
    test_reset_in_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
